// File: rtl/mac_accum_pipe_if.sv
// Stream bundle between the multiplier array, the MAC accumulator and the activation buffer.
// The slave side is the accumulator; the master side is whatever feeds and drains it.
interface mac_accum_pipe_if #(
  parameter int N_IN    = 6,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 32,
  parameter int SHIFT_W = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [N_IN*IN_W-1:0]   in_data;
  logic [IN_W-1:0]        bias;
  logic [SHIFT_W-1:0]     cfg_shift;
  logic                   cfg_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  modport master (
    output in_valid, in_first, in_last, in_data, bias, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, bias, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_accum_pipe.sv
// Three-stage multiply-accumulate tail: lane reduction, group accumulator, then
// shift / ReLU / saturation into a registered valid-ready output.
module mac_accum_pipe #(
  parameter int N_IN    = 6,
  parameter int IN_W    = 32,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 32,
  parameter int SHIFT_W = 5
) (
  input logic             clk,
  input logic             rst,
  mac_accum_pipe_if.slave bus
);

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] x);
    return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  logic                      stall;
  logic                      accept;
  logic signed [ACC_W-1:0]   lane_sum;

  logic [SHIFT_W-1:0]        cfg_shift_q;
  logic                      cfg_relu_q;

  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic signed [ACC_W-1:0]   s1_sum;
  logic [SHIFT_W-1:0]        s1_shift;
  logic                      s1_relu;

  logic                      s2_valid;
  logic signed [ACC_W-1:0]   acc;
  logic [SHIFT_W-1:0]        s2_shift;
  logic                      s2_relu;

  logic signed [ACC_W-1:0]   shifted;
  logic signed [ACC_W-1:0]   clipped;
  logic [OUT_W-1:0]          sat_data;
  logic                      sat_flag;

  logic                      out_valid_q;
  logic [OUT_W-1:0]          out_data_q;
  logic                      out_sat_q;

  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~rst & ~stall;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      lane_sum = lane_sum + sext(bus.in_data[i*IN_W +: IN_W]);
    end
    if (bus.in_first) begin
      lane_sum = lane_sum + sext(bus.bias);
    end
  end

  // Post-processing works at full accumulator width so the saturation test sees the true value.
  always_comb begin
    shifted  = acc >>> s2_shift;
    clipped  = (s2_relu && shifted < 0) ? '0 : shifted;
    sat_data = clipped[OUT_W-1:0];
    sat_flag = 1'b0;
    if (clipped > OUT_MAX) begin
      sat_data = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (clipped < OUT_MIN) begin
      sat_data = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  // Every stage advances together and freezes as a whole while the output is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_shift_q <= '0;
      cfg_relu_q  <= 1'b0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sum      <= '0;
      s1_shift    <= '0;
      s1_relu     <= 1'b0;
      s2_valid    <= 1'b0;
      acc         <= '0;
      s2_shift    <= '0;
      s2_relu     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= bus.in_first;
        s1_last  <= bus.in_last;
        s1_sum   <= lane_sum;
        s1_shift <= bus.in_first ? bus.cfg_shift : cfg_shift_q;
        s1_relu  <= bus.in_first ? bus.cfg_relu  : cfg_relu_q;
        if (bus.in_first) begin
          cfg_shift_q <= bus.cfg_shift;
          cfg_relu_q  <= bus.cfg_relu;
        end
      end

      s2_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc      <= s1_first ? s1_sum : acc + s1_sum;
        s2_shift <= s1_shift;
        s2_relu  <= s1_relu;
      end

      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q <= sat_data;
        out_sat_q  <= sat_flag;
      end
    end
  end

endmodule
